// File: rtl/counter_rate_scheduler_pkg.sv
// Shared types and constants for the counter rate scheduler.
package counter_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Latched rate mode of the granted requester
    typedef enum logic {
        MODE_SLOW = 1'b0,
        MODE_FAST = 1'b1
    } mode_e;

    localparam int NUM_REQ       = 2;
    localparam int DEF_SLOW_STEP = 1;
    localparam int DEF_FAST_STEP = 4;

    // One-hot grant vector for a requester index
    function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/counter_rate_scheduler_if.sv
// Requester-side handshake bundle: request, mode, step count, grant, done.
interface counter_rate_scheduler_if
    import counter_sched_pkg::*;
#(
    parameter int TICK_W = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_fast;
    logic [NUM_REQ*TICK_W-1:0] req_ticks;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;

    // Requester side drives the request fields
    modport master (
        output req, req_fast, req_ticks,
        input  gnt, done
    );

    // Scheduler side answers with grant and done
    modport slave (
        input  req, req_fast, req_ticks,
        output gnt, done
    );
endinterface

// File: rtl/counter_rate_scheduler_rate_prescaler.sv
// Loadable step prescaler: counts 0..TC and pulses tc_o on the terminal
// count. Two terminal counts are selectable (slow / fast rate).
module rate_prescaler #(
    parameter int unsigned      DIV_W   = 32,
    parameter logic [DIV_W-1:0] SLOW_TC = '0,
    parameter logic [DIV_W-1:0] FAST_TC = '0
) (
    input  logic clk_100MHz,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    input  logic fast_i,
    output logic tc_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] term;

    assign term = fast_i ? FAST_TC : SLOW_TC;
    assign tc_o = en_i && (cnt_q == term);

    // Next count: clear wins, otherwise wrap to zero on terminal count
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/counter_rate_scheduler.sv
// Round-robin scheduler sharing one dual-speed counter between two
// requesters. The winner's mode and step count are latched at grant; the
// prescaler paces step strobes of SLOW_STEP or FAST_STEP.
// Optional build macro COUNTER_SCHED_ABORT_EN: dropping req while running
// ends the run early (done still pulses). Without it, req drops are ignored
// until the run completes.
module counter_rate_scheduler
    import counter_sched_pkg::*;
#(
    parameter int unsigned SLOW_DIV  = 100000000,
    parameter int unsigned FAST_DIV  = 25000000,
    parameter int unsigned SLOW_STEP = DEF_SLOW_STEP,
    parameter int unsigned FAST_STEP = DEF_FAST_STEP,
    parameter int unsigned DIV_W     = 32,
    parameter int unsigned TICK_W    = 8
) (
    input  logic                     clk_100MHz,
    input  logic                     rst_n,
    counter_rate_scheduler_if.slave  req_if,
    output logic                     step_valid_o,
    output logic [7:0]               step_val_o,
    output logic                     busy_o
);
    localparam logic [DIV_W-1:0] SLOW_TC     = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0] FAST_TC     = DIV_W'(FAST_DIV - 1);
    localparam logic [7:0]       SLOW_STEP_V = 8'(SLOW_STEP);
    localparam logic [7:0]       FAST_STEP_V = 8'(FAST_STEP);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 step_valid_q, step_valid_d;
    logic [7:0]           step_val_q, step_val_d;
    logic [TICK_W-1:0]    ticks_left_q, ticks_left_d;
    mode_e                mode_q, mode_d;
    logic                 last_gnt_q, last_gnt_d;
    logic                 gnt_idx_q, gnt_idx_d;

    logic                 arb_valid;
    logic                 arb_idx;
    logic [TICK_W-1:0]    req_ticks_sel;
    logic                 abort;
    logic                 presc_clear;
    logic                 presc_en;
    logic                 presc_tc;

    rate_prescaler #(
        .DIV_W   (DIV_W),
        .SLOW_TC (SLOW_TC),
        .FAST_TC (FAST_TC)
    ) u_prescaler (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .clear_i    (presc_clear),
        .en_i       (presc_en),
        .fast_i     (mode_q == MODE_FAST),
        .tc_o       (presc_tc)
    );

    // Round-robin pick; a tie goes to the requester that was not served last.
    // No arbitration while the previous done pulse is still on the bus.
    always_comb begin
        arb_idx = 1'b0;
        case (req_if.req)
            2'b01:   arb_idx = 1'b0;
            2'b10:   arb_idx = 1'b1;
            2'b11:   arb_idx = ~last_gnt_q;
            default: arb_idx = 1'b0;
        endcase
        arb_valid     = (|req_if.req) && !(|done_q);
        req_ticks_sel = arb_idx ? req_if.req_ticks[TICK_W +: TICK_W]
                                : req_if.req_ticks[0 +: TICK_W];
    end

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort = (state_q == RUN) && !req_if.req[gnt_idx_q];
`else
    assign abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (arb_valid) state_d = (req_ticks_sel == '0) ? DONE : RUN;
            RUN:  if ((presc_tc && ticks_left_q == TICK_W'(1)) || abort) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values for the registered outputs
    always_comb begin
        gnt_d        = gnt_q;
        done_d       = '0;
        step_valid_d = 1'b0;
        step_val_d   = '0;
        ticks_left_d = ticks_left_q;
        mode_d       = mode_q;
        last_gnt_d   = last_gnt_q;
        gnt_idx_d    = gnt_idx_q;
        presc_clear  = 1'b0;
        presc_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|done_q) begin
                    // Grant is retired together with the done pulse
                    gnt_d = '0;
                end else if (arb_valid) begin
                    gnt_d        = onehot(arb_idx);
                    gnt_idx_d    = arb_idx;
                    mode_d       = mode_e'(req_if.req_fast[arb_idx]);
                    ticks_left_d = req_ticks_sel;
                    presc_clear  = 1'b1;
                end
            end
            RUN: begin
                presc_en = 1'b1;
                if (presc_tc) begin
                    step_valid_d = 1'b1;
                    step_val_d   = (mode_q == MODE_FAST) ? FAST_STEP_V : SLOW_STEP_V;
                    ticks_left_d = ticks_left_q - TICK_W'(1);
                end
            end
            DONE: begin
                done_d     = gnt_q;
                last_gnt_d = gnt_idx_q;
            end
            default: ;
        endcase
    end

    // Registered outputs and latched request context
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q        <= '0;
            done_q       <= '0;
            step_valid_q <= 1'b0;
            step_val_q   <= '0;
            ticks_left_q <= '0;
            mode_q       <= MODE_SLOW;
            last_gnt_q   <= 1'b1;
            gnt_idx_q    <= 1'b0;
        end else begin
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            step_valid_q <= step_valid_d;
            step_val_q   <= step_val_d;
            ticks_left_q <= ticks_left_d;
            mode_q       <= mode_d;
            last_gnt_q   <= last_gnt_d;
            gnt_idx_q    <= gnt_idx_d;
        end
    end

    assign req_if.gnt   = gnt_q;
    assign req_if.done  = done_q;
    assign step_valid_o = step_valid_q;
    assign step_val_o   = step_val_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_counter_rate_scheduler.sv
// Self-checking bench for counter_rate_scheduler (SLOW_DIV=8, FAST_DIV=2).
// Expectations come from a transaction-level model: grant one cycle after
// request, strobes every DIV cycles from grant, done one cycle after the
// last strobe, grant released the cycle after done.
module tb_counter_rate_scheduler;
    import counter_sched_pkg::*;

    localparam int SLOW_DIV = 8;
    localparam int FAST_DIV = 2;
    localparam int TICK_W   = 8;

    logic       clk_100MHz = 1'b0;
    logic       rst_n      = 1'b1;
    logic       step_valid;
    logic [7:0] step_val;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;
    int last_gnt = 1;

    counter_rate_scheduler_if #(.TICK_W(TICK_W)) req_if ();

    counter_rate_scheduler #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV),
        .TICK_W   (TICK_W)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .rst_n        (rst_n),
        .req_if       (req_if.slave),
        .step_valid_o (step_valid),
        .step_val_o   (step_val),
        .busy_o       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic set_req(input int idx, input bit on, input bit fast, input int ticks);
        req_if.req[idx]                        = on;
        req_if.req_fast[idx]                   = fast;
        req_if.req_ticks[idx*TICK_W +: TICK_W] = TICK_W'(ticks);
    endtask

    // Round-robin rule: lone requester wins; a tie goes to the one not served last
    function automatic int pick(input logic [1:0] mask, input int last);
        if (mask == 2'b11) return (last == 0) ? 1 : 0;
        return mask[1] ? 1 : 0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " gnt"},        32'(req_if.gnt),  32'd0);
        check({tag, " done"},       32'(req_if.done), 32'd0);
        check({tag, " step_valid"}, 32'(step_valid),  32'd0);
        check({tag, " step_val"},   32'(step_val),    32'd0);
        check({tag, " busy"},       32'(busy),        32'd0);
    endtask

    // Follow one granted run. Precondition: the next clock edge grants idx.
    // drop_after > 0 drops req right after that many strobes have been seen.
    task automatic serve(input int idx, input bit fast, input int ticks,
                         input bit keep, input int drop_after);
        int         div, last_c, done_c, dc;
        logic [1:0] oh;
        bit         exp_sv;
        logic [7:0] exp_val;
        div    = fast ? FAST_DIV : SLOW_DIV;
        oh     = 2'b01 << idx;
        dc     = drop_after * div;
        last_c = ticks * div;
        done_c = ticks * div + 1;
`ifdef COUNTER_SCHED_ABORT_EN
        if (drop_after > 0) begin
            last_c = dc + 1;
            done_c = dc + 2;
        end
`endif
        tick();
        check($sformatf("grant r%0d", idx), 32'(req_if.gnt), 32'(oh));
        check($sformatf("grant busy r%0d", idx), 32'(busy), 32'd1);
        for (int c = 1; c <= done_c; c++) begin
            tick();
            exp_sv  = (c % div == 0) && (c <= last_c);
            exp_val = exp_sv ? (fast ? 8'd4 : 8'd1) : 8'd0;
            check($sformatf("step_valid r%0d c%0d", idx, c), 32'(step_valid), 32'(exp_sv));
            check($sformatf("step_val r%0d c%0d", idx, c), 32'(step_val), 32'(exp_val));
            check($sformatf("gnt held r%0d c%0d", idx, c), 32'(req_if.gnt), 32'(oh));
            check($sformatf("done r%0d c%0d", idx, c), 32'(req_if.done),
                  (c == done_c) ? 32'(oh) : 32'd0);
            if (drop_after > 0 && c == dc) req_if.req[idx] = 1'b0;
            if (c == done_c && !keep) req_if.req[idx] = 1'b0;
        end
        tick();
        check($sformatf("gnt released r%0d", idx), 32'(req_if.gnt), 32'd0);
        check($sformatf("done cleared r%0d", idx), 32'(req_if.done), 32'd0);
        check($sformatf("no strobe after r%0d", idx), 32'(step_valid), 32'd0);
        last_gnt = idx;
    endtask

    initial begin
        logic [1:0] mask;
        bit         rfast [2];
        int         rticks[2];
        int         w;

        req_if.req       = '0;
        req_if.req_fast  = '0;
        req_if.req_ticks = '0;

        // Reset asserted, then released
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("in reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("after reset");

        // Single slow request, three steps
        set_req(0, 1, 0, 3);
        serve(pick(2'b01, last_gnt), 0, 3, 0, 0);
        tick();
        check("idle busy", 32'(busy), 32'd0);

        // Reset dropped in the middle of a fast run
        set_req(0, 1, 1, 5);
        repeat (4) tick();
        check("mid-run busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1 check_idle_outputs("mid-run reset");
        set_req(0, 0, 0, 0);
        repeat (2) tick();
        check("no done in reset", 32'(req_if.done), 32'd0);
        rst_n    = 1'b1;
        last_gnt = 1;
        tick();
        check_idle_outputs("after abort reset");

        // Both requesters raised together: 0 first, then 1 in fast mode
        set_req(0, 1, 0, 1);
        set_req(1, 1, 1, 4);
        w = pick(2'b11, last_gnt);
        serve(w, 0, 1, 0, 0);
        w = pick(2'b10, last_gnt);
        serve(w, 1, 4, 0, 0);

        // Continuous re-requests alternate grants
        set_req(0, 1, 1, 1);
        set_req(1, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            w = pick(2'b11, last_gnt);
            serve(w, 1, 1, 1, 0);
        end
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        tick();
        check("no grant after release", 32'(req_if.gnt), 32'd0);

        // Zero-tick request bypasses the run
        set_req(0, 1, 0, 0);
        serve(pick(2'b01, last_gnt), 0, 0, 0, 0);

        // Requester 0 drops req after its second fast strobe
        set_req(0, 1, 1, 10);
        serve(pick(2'b01, last_gnt), 1, 10, 0, 2);
        tick();
        check("idle after drop run", 32'(req_if.gnt), 32'd0);

        // Randomized request mixes
        for (int it = 0; it < 8; it++) begin
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                rfast[i]  = 1'($urandom_range(0, 1));
                rticks[i] = int'($urandom_range(0, 4));
                if (mask[i]) set_req(i, 1, rfast[i], rticks[i]);
            end
            while (mask != 2'b00) begin
                w = pick(mask, last_gnt);
                serve(w, rfast[w], rticks[w], 0, 0);
                mask[w] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
